// File: rtl/sram_pkg.sv
// Shared state encoding, default geometry and timing for the SRAM access controller.
package sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } sram_state_t;

    localparam int unsigned ADDR_W_DEF  = 20;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned RD_WAIT_DEF = 2;
    localparam int unsigned WR_WAIT_DEF = 2;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Down-counter must hold the larger wait minus one, plus headroom bit.
    function automatic int unsigned wait_cnt_width(input int unsigned rd_wait,
                                                   input int unsigned wr_wait);
        return $clog2(max_u(rd_wait, wr_wait)) + 1;
    endfunction

endpackage

// File: rtl/sram_access_ctrl_wait_count.sv
// Loadable down-counter shared by the read and write-pulse states; zero_o marks the last cycle.
module wait_count #(
    parameter int unsigned W = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/sram_access_ctrl.sv
// Single-word request sequencer for an external async SRAM: registered strobes,
// parameterised wait states, owned bidirectional data bus and registered read data.
module sram_access_ctrl
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned RD_WAIT = RD_WAIT_DEF,
    parameter int unsigned WR_WAIT = WR_WAIT_DEF
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        byte_en,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata,
    output logic              CE,
    output logic              UB,
    output logic              LB,
    output logic              OE,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Data
);

    localparam int unsigned CNT_W = wait_cnt_width(RD_WAIT, WR_WAIT);

    if (RD_WAIT == 0) begin : g_rd_wait_chk
        $error("sram_access_ctrl: RD_WAIT must be at least 1");
    end
    if (WR_WAIT == 0) begin : g_wr_wait_chk
        $error("sram_access_ctrl: WR_WAIT must be at least 1");
    end

    sram_state_t       state_q;
    logic              ready_q;
    logic              done_q;
    logic [DATA_W-1:0] rdata_q;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ce_q;
    logic              ub_q;
    logic              lb_q;
    logic              oe_q;
    logic              we_q;
    logic              drive_en_q;

    logic              cnt_load;
    logic [CNT_W-1:0]  cnt_load_val;
    logic              cnt_en;
    logic              cnt_zero;

    // Counter is loaded on entry to RD (from IDLE) and to WR_PULSE (from WR_SETUP).
    always_comb begin
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_en       = (state_q == RD) || (state_q == WR_PULSE);
        if ((state_q == IDLE) && req && !we) begin
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(RD_WAIT - 1);
        end else if (state_q == WR_SETUP) begin
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(WR_WAIT - 1);
        end
    end

    wait_count #(
        .W (CNT_W)
    ) u_wait_count (
        .clk_i      (Clk),
        .rst_ni     (Reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .en_i       (cnt_en),
        .zero_o     (cnt_zero)
    );

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q    <= IDLE;
            ready_q    <= 1'b1;
            done_q     <= 1'b0;
            rdata_q    <= '0;
            wdata_q    <= '0;
            addr_q     <= '0;
            ce_q       <= 1'b1;
            ub_q       <= 1'b1;
            lb_q       <= 1'b1;
            oe_q       <= 1'b1;
            we_q       <= 1'b1;
            drive_en_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (req) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        ready_q <= 1'b0;
                        ce_q    <= 1'b0;
                        if (we) begin
                            state_q    <= WR_SETUP;
                            ub_q       <= ~byte_en[1];
                            lb_q       <= ~byte_en[0];
                            drive_en_q <= 1'b1;
                        end else begin
                            state_q <= RD;
                            ub_q    <= 1'b0;
                            lb_q    <= 1'b0;
                            oe_q    <= 1'b0;
                        end
                    end
                end
                RD: begin
                    if (cnt_zero) begin
                        rdata_q <= Data;
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        ce_q    <= 1'b1;
                        ub_q    <= 1'b1;
                        lb_q    <= 1'b1;
                        oe_q    <= 1'b1;
                    end
                end
                WR_SETUP: begin
                    state_q <= WR_PULSE;
                    we_q    <= 1'b0;
                end
                WR_PULSE: begin
                    if (cnt_zero) begin
                        state_q <= WR_HOLD;
                        we_q    <= 1'b1;
                    end
                end
                WR_HOLD: begin
                    state_q    <= IDLE;
                    ready_q    <= 1'b1;
                    done_q     <= 1'b1;
                    ce_q       <= 1'b1;
                    ub_q       <= 1'b1;
                    lb_q       <= 1'b1;
                    drive_en_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign Data  = drive_en_q ? wdata_q : 'z;

    assign ready = ready_q;
    assign done  = done_q;
    assign rdata = rdata_q;
    assign CE    = ce_q;
    assign UB    = ub_q;
    assign LB    = lb_q;
    assign OE    = oe_q;
    assign WE    = we_q;
    assign ADDR  = addr_q;

endmodule
